ysyx_23060124_axil_sram: RTL and testbench
==========================================

# ysyx_23060124_axil_sram

AXI4-Lite slave memory that serves as the responder for the core's instruction-fetch and load/store initiators. It accepts one read or write transaction at a time, holds a word-addressed internal array, and returns responses after a programmable access latency. It replaces the DPI memory model at the far end of the IFU/LSU bus and lets the core be exercised against realistic handshakes and wait states.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of array depth in 32-bit words (default 16 KiB).
- LATENCY, 1, cycles from request handshake to response valid; legal range 1..15.

- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- araddr  input  32  read address.
- arvalid  input  1  read address valid.
- arready  output  1  read address ready.
- rdata  output  32  read data.
- rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  output  1  read response valid.
- rready  input  1  read response ready.
- awaddr  input  32  write address.
- awvalid  input  1  write address valid.
- awready  output  1  write address ready.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  input  1  write data valid.
- wready  output  1  write data ready.
- bresp  output  2  write response, encoding as rresp.
- bvalid  output  1  write response valid.
- bready  input  1  write response ready.

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- arready = IDLE && !rst. awready = wready = IDLE && !rst && awvalid && wvalid && !arvalid.
- Read has priority: if arvalid, awvalid, and wvalid are all high in IDLE, the read is accepted; the write waits until the FSM returns to IDLE.
- A write is accepted only with AW and W together; no independent AW or W acceptance.
- Decode: offset = addr - BASE_ADDR; in range iff offset < 4*2^DEPTH_LOG2; index = offset[DEPTH_LOG2+1:2]; addr[1:0] ignored (aligned down).
- Write: the array is updated at the handshake edge, per wstrb byte. Out-of-range writes have no effect and return bresp 2'b10.
- Read: rdata is sampled from the array on entry to RD_RESP. Out-of-range reads return rdata 0 and rresp 2'b10.
- Delay counter: loaded with LATENCY-1 at acceptance; *_WAIT decrements it; at 0, the FSM moves to *_RESP. LATENCY=1 goes directly to *_RESP.
- *_RESP holds valid, data, and resp stable until ready. On handshake, the FSM goes to IDLE.
- Array is not reset; committed writes survive rst.

## Timing
- Reset values: arready 0, awready 0, wready 0, rvalid 0, bvalid 0, rdata 0, rresp 2'b00, bresp 2'b00, state IDLE, counter 0.
- Reset assertion mid-transaction: valids drop asynchronously and the pending transaction is discarded. A write already committed stays.
- Request handshake at edge E0 → response valid after edge E_LATENCY.
- Response handshake at edge Ek → ready outputs high in the cycle after Ek.
- Next request is accepted no earlier than edge Ek+1.
- Throughput with rready/bready tied high: one transaction per LATENCY+1 cycles.
- No combinational path from rready/bready to any output. Ready outputs depend on state and the request valids only.

## Configuration
- YSYX_23060124_SRAM_RAND_DELAY_EN defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'h5A on rst, advances every cycle.
  - Counter is loaded with LATENCY-1+lfsr[2:0] at acceptance, so latency ranges LATENCY..LATENCY+7.
- Undefined: latency is exactly LATENCY; no LFSR logic.

## Test plan
- Reset: rst high 3 cycles → all outputs at reset values; arready 1 in the first cycle after rst falls.
- Write/read, LATENCY=1:
  - Write 0xDEADBEEF to 0x8000_0010, wstrb 4'hF → bvalid 1 cycle after handshake, bresp 2'b00.
  - Read 0x8000_0010 → rdata 0xDEADBEEF, rresp 2'b00, rvalid 1 cycle after AR handshake.
- Byte strobes: write 0x11223344, wstrb 4'b0101, over 0xDEADBEEF → readback 0xDE22BE44.
- Collision: arvalid, awvalid, and wvalid asserted in the same IDLE cycle → read accepted, awready 0 throughout the read; write accepted the cycle after the R handshake.
- Out of range:
  - Read 0x7FFF_FFFC → rdata 0, rresp 2'b10.
  - Write to BASE_ADDR+4*2^DEPTH_LOG2 → bresp 2'b10; a later in-range read is unchanged.
- Backpressure and reset, LATENCY=3:
  - rready low 5 cycles → rvalid and rdata stable, arready 0.
  - rst pulsed during RD_WAIT → rvalid 0 immediately; array contents intact.
  - With the macro defined: 50 reads, each latency within 3..10 cycles.

Source files
------------

// File: rtl/ysyx_23060124_axil_sram.sv
// AXI4-Lite slave memory for the IFU/LSU buses: one outstanding transaction,
// word-addressed array, programmable access latency, read-over-write priority.
// Optional feature: define YSYX_23060124_SRAM_RAND_DELAY_EN to add 0..7 extra
// wait cycles per transaction, drawn from an 8-bit LFSR.
module ysyx_23060124_axil_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int              DEPTH  = 1 << DEPTH_LOG2;
  localparam int              CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next, cnt_load;
  logic [31:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  rd_idx, rd_sel_idx, ar_idx, aw_idx;
  logic                   rd_ok, rd_sel_ok, ar_in, aw_in, rd_load;
  logic [31:0]            ar_off, aw_off;
  logic                   ar_hs, aw_hs;
  logic [3:0]             unused_bits;

  // Address decode: byte offset from the base, word index, range check.
  assign ar_off      = araddr - BASE_ADDR;
  assign aw_off      = awaddr - BASE_ADDR;
  assign ar_in       = (ar_off[31:DEPTH_LOG2+2] == '0);
  assign aw_in       = (aw_off[31:DEPTH_LOG2+2] == '0);
  assign ar_idx      = ar_off[DEPTH_LOG2+1:2];
  assign aw_idx      = aw_off[DEPTH_LOG2+1:2];
  assign unused_bits = {ar_off[1:0], aw_off[1:0]};

  // Request readies depend only on state, reset and the request valids.
  assign arready = (state == IDLE) && !rst;
  assign awready = (state == IDLE) && !rst && awvalid && wvalid && !arvalid;
  assign wready  = awready;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign rvalid  = (state == RD_RESP);
  assign bvalid  = (state == WR_RESP);

  // With LATENCY=1 the array is read on the acceptance edge itself, before
  // rd_idx has been captured, so take the index straight from the bus then.
  assign rd_sel_idx = (state == IDLE) ? ar_idx : rd_idx;
  assign rd_sel_ok  = (state == IDLE) ? ar_in  : rd_ok;

`ifdef YSYX_23060124_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'h5A;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_load = LAT_M1 + CNT_W'(lfsr[2:0]);
`else
  assign cnt_load = LAT_M1;
`endif

  // Next-state logic: accept, count down the wait, hold response until ready.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    rd_load    = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          if (cnt_load == '0) begin
            state_next = RD_RESP;
            rd_load    = 1'b1;
          end else begin
            state_next = RD_WAIT;
            cnt_next   = cnt_load;
          end
        end else if (aw_hs) begin
          if (cnt_load == '0) begin
            state_next = WR_RESP;
          end else begin
            state_next = WR_WAIT;
            cnt_next   = cnt_load;
          end
        end
      end
      RD_WAIT: begin
        cnt_next = (cnt == '0) ? '0 : cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_next = RD_RESP;
          rd_load    = 1'b1;
        end
      end
      WR_WAIT: begin
        cnt_next = (cnt == '0) ? '0 : cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_next = WR_RESP;
      end
      RD_RESP: if (rready) state_next = IDLE;
      WR_RESP: if (bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= IDLE;
      cnt    <= '0;
      rdata  <= '0;
      rresp  <= OKAY;
      bresp  <= OKAY;
      rd_idx <= '0;
      rd_ok  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (ar_hs) begin
        rd_idx <= ar_idx;
        rd_ok  <= ar_in;
      end
      if (rd_load) begin
        rdata <= rd_sel_ok ? mem[rd_sel_idx] : 32'h0;
        rresp <= rd_sel_ok ? OKAY : SLVERR;
      end
      if (aw_hs) bresp <= aw_in ? OKAY : SLVERR;
    end
  end

  // Byte-enabled array write on the write handshake edge.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose; contents must survive rst.
    if (aw_hs && aw_in) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[aw_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_axil_sram.sv
// Directed bench for ysyx_23060124_axil_sram: one instance with LATENCY=1
// (index 0) and one with LATENCY=3 (index 1) on a shared clock and reset.
module tb_ysyx_23060124_axil_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2];
  logic        bvalid [2], bready [2];
  logic [1:0]  rresp  [2], bresp  [2];
  logic [3:0]  wstrb  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060124_axil_sram #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_23060124_axil_sram #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a read address and complete the AR handshake; returns just after it.
  task automatic ar_start(input int d, input logic [31:0] a, input logic rr);
    int n;
    @(negedge clk);
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = rr;
    #1;
    n = 0;
    while (!arready[d] && n < 50) begin @(negedge clk); #1; n++; end
    check("ar_accept_timeout", (n >= 50) ? 1 : 0, 0);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
  endtask

  // Full read; lat counts cycles from the AR handshake edge to rvalid.
  task automatic rd(input int d, input logic [31:0] a,
                    output logic [31:0] data, output logic [1:0] resp, output int lat);
    ar_start(d, a, 1'b1);
    lat = 1;
    while (!rvalid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    data = rdata[d];
    resp = rresp[d];
    @(posedge clk); #1;
    rready[d] = 1'b0;
  endtask

  // Full write; lat counts cycles from the AW/W handshake edge to bvalid.
  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data,
                    input logic [3:0] s, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    awaddr[d] = a; wdata[d] = data; wstrb[d] = s;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
    #1;
    n = 0;
    while (!awready[d] && n < 50) begin @(negedge clk); #1; n++; end
    check("aw_accept_timeout", (n >= 50) ? 1 : 0, 0);
    @(posedge clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    lat = 1;
    while (!bvalid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    resp = bresp[d];
    @(posedge clk); #1;
    bready[d] = 1'b0;
  endtask

  // Hard stop in case some unbounded path slips through.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    int          seen;

    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d]  = '0;
      wstrb[d]  = '0; wvalid[d]  = 1'b0; bready[d] = 1'b0;
    end
    // Hold write valids high during reset: awready must still stay low.
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", arready[0], 0);
    check("rst_awready", awready[0], 0);
    check("rst_wready",  wready[0],  0);
    check("rst_rvalid",  rvalid[0],  0);
    check("rst_bvalid",  bvalid[0],  0);
    check("rst_rdata",   rdata[0],   0);
    check("rst_rresp",   rresp[0],   0);
    check("rst_bresp",   bresp[0],   0);
    check("rst_arready3", arready[1], 0);
    check("rst_rvalid3",  rvalid[1],  0);
    @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_arready",  arready[0], 1);
    check("post_rst_arready3", arready[1], 1);

    // Basic write/read with LATENCY=1.
    wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
    check("wr_bresp", resp, 2'b00);
    check("wr_lat1",  lat,  1);
    rd(0, 32'h8000_0010, data, resp, lat);
    check("rd_data",  data, 32'hDEAD_BEEF);
    check("rd_rresp", resp, 2'b00);
    check("rd_lat1",  lat,  1);
    check("arready_after_rhs", arready[0], 1);

    // Byte strobes, with an unaligned address that must align down.
    wr(0, 32'h8000_0013, 32'h1122_3344, 4'b0101, resp, lat);
    rd(0, 32'h8000_0010, data, resp, lat);
    check("strobe_data", data, 32'hDE22_BE44);

    // Read/write collision: read wins, write follows the R handshake.
    @(negedge clk);
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b1;
    awaddr[0] = 32'h8000_0020; wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    #1;
    check("col_arready", arready[0], 1);
    check("col_awready_idle", awready[0], 0);
    check("col_wready_idle",  wready[0],  0);
    @(posedge clk); #1;
    arvalid[0] = 1'b0;
    check("col_rvalid", rvalid[0], 1);
    check("col_rdata",  rdata[0],  32'hDE22_BE44);
    check("col_awready_rresp", awready[0], 0);
    @(posedge clk); #1;
    check("col_rvalid_done", rvalid[0], 0);
    check("col_awready_next", awready[0], 1);
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    check("col_bvalid", bvalid[0], 1);
    check("col_bresp",  bresp[0],  2'b00);
    @(posedge clk); #1;
    bready[0] = 1'b0; rready[0] = 1'b0;
    rd(0, 32'h8000_0020, data, resp, lat);
    check("col_wr_data", data, 32'hCAFE_F00D);

    // Out-of-range accesses.
    rd(0, 32'h7FFF_FFFC, data, resp, lat);
    check("oor_rd_data", data, 32'h0);
    check("oor_rd_resp", resp, 2'b10);
    wr(0, BASE, 32'h1234_5678, 4'hF, resp, lat);
    wr(0, BASE + 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, resp, lat);
    check("oor_wr_resp", resp, 2'b10);
    rd(0, BASE, data, resp, lat);
    check("oor_wr_word0", data, 32'h1234_5678);
    check("oor_wr_word0_resp", resp, 2'b00);

    // LATENCY=3 instance: write/read latency.
    wr(1, 32'h8000_0100, 32'hA5A5_0001, 4'hF, resp, lat);
    check("l3_wr_resp", resp, 2'b00);
`ifdef YSYX_23060124_SRAM_RAND_DELAY_EN
    check("l3_wr_lat_range", (lat >= 3 && lat <= 10) ? 1 : 0, 1);
`else
    check("l3_wr_lat", lat, 3);
`endif
    rd(1, 32'h8000_0100, data, resp, lat);
    check("l3_rd_data", data, 32'hA5A5_0001);

    // Backpressure: rready low for 5 cycles, then reset while in RD_RESP.
    ar_start(1, 32'h8000_0100, 1'b0);
    seen = 0;
    while (!rvalid[1] && seen < 50) begin @(posedge clk); #1; seen++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  rvalid[1],  1);
      check("bp_rdata",   rdata[1],   32'hA5A5_0001);
      check("bp_arready", arready[1], 0);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("bp_rst_rvalid", rvalid[1], 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset pulse while the read is still waiting out its latency.
    ar_start(1, 32'h8000_0100, 1'b1);
    check("rw_state_wait", rvalid[1], 0);
    rst = 1'b1;
    #1;
    check("rw_rst_rvalid", rvalid[1], 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rvalid[1]) seen++;
    end
    check("rw_discarded", seen, 0);
    rready[1] = 1'b0;
    rd(1, 32'h8000_0100, data, resp, lat);
    check("rw_array_intact", data, 32'hA5A5_0001);
    rd(0, 32'h8000_0020, data, resp, lat);
    check("rw_array_intact0", data, 32'hCAFE_F00D);

    // Repeated reads: latency bounds and data.
    for (int i = 0; i < 50; i++) begin
      rd(1, 32'h8000_0100, data, resp, lat);
      check("loop_data", data, 32'hA5A5_0001);
`ifdef YSYX_23060124_SRAM_RAND_DELAY_EN
      check("loop_lat_range", (lat >= 3 && lat <= 10) ? 1 : 0, 1);
`else
      check("loop_lat", lat, 3);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
